// File: rtl/frequency_counter_multilevel.sv
// Multi-level period counter: measures INPUT_PERIODS cycles of an asynchronous
// square wave against clk_200M, back to back with no dead time, and quantises
// each window count into one of 2**OUTPUT_BITS symbols using runtime thresholds
// Tk = bin_base_i + k*bin_step_i. A lost input is reported by a timeout strobe.
//
// Strobe semantics: valid_o and timeout_o are single-cycle pulses with no
// back-pressure. valid_o marks the cycle in which sample_o/symbol_o take new
// values. timeout_o marks an abandoned window. The two are never high together.
`timescale 1ns/1ps
module frequency_counter_multilevel #(
  parameter int COUNT_WIDTH   = 16,
  parameter int OUTPUT_BITS   = 2,
  parameter int INPUT_PERIODS = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 4095
) (
  input  logic                   clk_200M,
  input  logic                   reset_n_200M,
  input  logic                   input_frequency,
  input  logic                   enable_i,
  input  logic [COUNT_WIDTH-1:0] bin_base_i,
  input  logic [COUNT_WIDTH-1:0] bin_step_i,
  output logic [COUNT_WIDTH-1:0] sample_o,
  output logic [OUTPUT_BITS-1:0] symbol_o,
  output logic                   valid_o,
  output logic                   timeout_o,
  output logic [1:0]             fsm_state
);

  localparam int NUM_FREQUENCIES = 2 ** OUTPUT_BITS;
  localparam int EDGE_WIDTH      = $clog2(INPUT_PERIODS + 1);
  localparam int THR_WIDTH       = COUNT_WIDTH + OUTPUT_BITS;

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT);
  localparam logic [EDGE_WIDTH-1:0]  LAST_EDGE   = EDGE_WIDTH'(INPUT_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic [EDGE_WIDTH-1:0]  edges_q, edges_d;
  logic [COUNT_WIDTH-1:0] sample_d;
  logic [OUTPUT_BITS-1:0] symbol_d;
  logic                   valid_d, timeout_d;
  logic                   closing;

  logic [OUTPUT_BITS-1:0] sym_next;
  logic [THR_WIDTH-1:0]   thr;
  logic [THR_WIDTH-1:0]   ext_base, ext_step, ext_count;

  assign fsm_state = state_q;

  // Synchroniser chain plus history flop; the fixed depth delays every edge
  // equally, so window lengths are not biased.
  always_ff @(posedge clk_200M) begin
    if (!reset_n_200M) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], input_frequency};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign closing = rise && (edges_q == LAST_EDGE);

  assign ext_base  = {{OUTPUT_BITS{1'b0}}, bin_base_i};
  assign ext_step  = {{OUTPUT_BITS{1'b0}}, bin_step_i};
  assign ext_count = {{OUTPUT_BITS{1'b0}}, counter_q};

  // Quantiser: symbol is the number of thresholds strictly above the count,
  // computed in a widened domain so large thresholds never wrap.
  always_comb begin
    sym_next = '0;
    thr      = '0;
    for (int k = 0; k < NUM_FREQUENCIES - 1; k++) begin
      thr = ext_base + THR_WIDTH'(k) * ext_step;
      if (ext_count < thr) sym_next = sym_next + OUTPUT_BITS'(1);
    end
  end

  // Next-state and datapath: a closing edge ends one window and opens the next.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    edges_d   = edges_q;
    sample_d  = sample_o;
    symbol_d  = symbol_o;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!enable_i) begin
      state_d   = IDLE;
      counter_d = '0;
      edges_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          counter_d = '0;
          edges_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d   = COUNT;
            counter_d = COUNT_WIDTH'(1);
            edges_d   = '0;
          end
        end
        COUNT: begin
          if (closing) begin
            sample_d  = counter_q;
            symbol_d  = sym_next;
            valid_d   = 1'b1;
            counter_d = COUNT_WIDTH'(1);
            edges_d   = '0;
          end else if (counter_q == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
            state_d   = ARM;
            counter_d = '0;
            edges_d   = '0;
          end else begin
            counter_d = counter_q + COUNT_WIDTH'(1);
            if (rise) edges_d = edges_q + EDGE_WIDTH'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
          edges_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_200M) begin
    if (!reset_n_200M) begin
      state_q   <= IDLE;
      counter_q <= '0;
      edges_q   <= '0;
      sample_o  <= '0;
      symbol_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      edges_q   <= edges_d;
      sample_o  <= sample_d;
      symbol_o  <= symbol_d;
      valid_o   <= valid_d;
      timeout_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_frequency_counter_multilevel.sv
// Directed bench for frequency_counter_multilevel: steady and stepped input
// periods, timeout and restart, enable drop, mid-window reset, threshold edge
// cases and sub-cycle jitter. Expected {symbol, sample} pairs are hand-computed.
`timescale 1ns/1ps
module tb_frequency_counter_multilevel;

  localparam int CW = 16;
  localparam int OB = 2;

  // ---------------- clock / reset ----------------
  logic          clk_200M = 1'b0;
  logic          reset_n_200M = 1'b0;
  logic          input_frequency = 1'b0;
  logic          enable_i = 1'b0;
  logic [CW-1:0] bin_base_i = '0;
  logic [CW-1:0] bin_step_i = '0;
  logic [CW-1:0] sample_o;
  logic [OB-1:0] symbol_o;
  logic          valid_o;
  logic          timeout_o;
  logic [1:0]    fsm_state;

  always #2.5 clk_200M = ~clk_200M;

  frequency_counter_multilevel dut (
    .clk_200M        (clk_200M),
    .reset_n_200M    (reset_n_200M),
    .input_frequency (input_frequency),
    .enable_i        (enable_i),
    .bin_base_i      (bin_base_i),
    .bin_step_i      (bin_step_i),
    .sample_o        (sample_o),
    .symbol_o        (symbol_o),
    .valid_o         (valid_o),
    .timeout_o       (timeout_o),
    .fsm_state       (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int timeout_cnt = 0;
  int last_valid_cyc = 0;
  int last_timeout_cyc = 0;
  int jit_cnt = 0;
  bit jit_mode = 1'b0;
  int vq[$];
  logic [CW+OB-1:0] exp_q[$];
  logic [CW+OB-1:0] e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // n rising edges, period p clocks, edges 1ns after posedge; ends low,
  // exactly p clocks after the last rise.
  task automatic drive_periods(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      input_frequency = 1'b1;
      repeat (p / 2) @(posedge clk_200M);
      #1;
      input_frequency = 1'b0;
      repeat (p - p / 2) @(posedge clk_200M);
      #1;
    end
  endtask

  // n rising edges on a 200ns (40 clk) grid, each displaced by up to ~0.4 clk.
  // Offsets avoid landing on a clock edge.
  task automatic drive_jitter(input int n);
    realtime t0, t_rise;
    int d_ps;
    t0 = $realtime;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) d_ps = int'($urandom_range(0, 1900));
      else d_ps = -int'($urandom_range(1200, 1900));
      t_rise = t0 + i * 200.0 + d_ps / 1000.0;
      #(t_rise - $realtime);
      input_frequency = 1'b1;
      #100;
      input_frequency = 1'b0;
    end
    #(t0 + n * 200.0 - $realtime);
  endtask

  // ---------------- monitor ----------------
  // Samples outputs on the falling edge, away from the active edge.
  always @(negedge clk_200M) begin
    cyc++;
    if (valid_o || timeout_o) check_eq("strobe_excl", 32'(valid_o & timeout_o), 32'd0);
    if (timeout_o) begin
      timeout_cnt++;
      last_timeout_cyc = cyc;
    end
    if (valid_o) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      vq.push_back(cyc);
      if (jit_mode) begin
        jit_cnt++;
        check_eq("jit_range", 32'(sample_o >= 16'd199 && sample_o <= 16'd201), 32'd1);
        check_eq("jit_symbol", 32'(symbol_o), (sample_o == 16'd199) ? 32'd1 : 32'd0);
      end else begin
        check_eq("exp_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sample", 32'(sample_o), 32'(e[CW-1:0]));
          check_eq("symbol", 32'(symbol_o), 32'(e[CW+OB-1:CW]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int v0, t0, start_cyc, d;

    // Reset state
    repeat (4) @(posedge clk_200M);
    @(negedge clk_200M);
    check_eq("rst_sample", 32'(sample_o), 32'd0);
    check_eq("rst_symbol", 32'(symbol_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk_200M); #1;
    reset_n_200M = 1'b1;
    bin_base_i = 16'd190;
    bin_step_i = 16'd5;
    repeat (3) @(posedge clk_200M); #1;
    enable_i = 1'b1;
    repeat (2) @(posedge clk_200M);
    @(negedge clk_200M);
    check_eq("arm_state", 32'(fsm_state), 32'd1);
    @(posedge clk_200M); #1;

    // Steady 40, then 38 / 36 / 42, windows back to back
    exp_q.push_back({2'd0, 16'd200});
    exp_q.push_back({2'd0, 16'd200});
    exp_q.push_back({2'd0, 16'd200});
    exp_q.push_back({2'd2, 16'd190});
    exp_q.push_back({2'd3, 16'd180});
    exp_q.push_back({2'd0, 16'd210});
    drive_periods(40, 15);
    drive_periods(38, 5);
    drive_periods(36, 5);
    drive_periods(42, 5);
    drive_periods(40, 1);   // closes the 42 window, then input stops

    // Timeout with no further edges
    t0 = timeout_cnt;
    for (int i = 0; i < 4300 && timeout_cnt == t0; i++) @(negedge clk_200M);
    check_eq("timeout_seen", 32'(timeout_cnt - t0), 32'd1);
    check_eq("timeout_delay", 32'(last_timeout_cyc - last_valid_cyc), 32'd4095);
    check_eq("valid_count_a", 32'(valid_cnt), 32'd6);
    check_eq("timeout_sample_hold", 32'(sample_o), 32'd210);
    if (vq.size() >= 6) begin
      check_eq("gap_1", 32'(vq[1] - vq[0]), 32'd200);
      check_eq("gap_2", 32'(vq[2] - vq[1]), 32'd200);
      check_eq("gap_3", 32'(vq[3] - vq[2]), 32'd190);
      check_eq("gap_4", 32'(vq[4] - vq[3]), 32'd180);
      check_eq("gap_5", 32'(vq[5] - vq[4]), 32'd210);
    end
    @(posedge clk_200M); #1;

    // Restart: one arming edge plus five periods
    exp_q.push_back({2'd0, 16'd200});
    start_cyc = cyc;
    drive_periods(40, 6);
    check_eq("valid_count_b", 32'(valid_cnt), 32'd7);
    d = last_valid_cyc - start_cyc;
    check_eq("restart_latency", 32'(d >= 200 && d <= 206), 32'd1);

    // Enable low for one cycle mid-window: window discarded, no strobes
    drive_periods(40, 3);
    v0 = valid_cnt;
    t0 = timeout_cnt;
    enable_i = 1'b0;
    @(posedge clk_200M); #1;
    enable_i = 1'b1;
    @(negedge clk_200M);
    check_eq("dis_state", 32'(fsm_state), 32'd0);
    repeat (2) @(negedge clk_200M);
    check_eq("dis_sample_hold", 32'(sample_o), 32'd200);
    check_eq("dis_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_eq("dis_no_timeout", 32'(timeout_cnt - t0), 32'd0);
    @(posedge clk_200M); #1;
    exp_q.push_back({2'd0, 16'd200});
    drive_periods(40, 6);
    check_eq("valid_count_c", 32'(valid_cnt - v0), 32'd1);

    // Reset mid-window
    drive_periods(40, 3);
    reset_n_200M = 1'b0;
    @(posedge clk_200M);
    @(negedge clk_200M);
    check_eq("mid_rst_sample", 32'(sample_o), 32'd0);
    check_eq("mid_rst_symbol", 32'(symbol_o), 32'd0);
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk_200M); #1;
    reset_n_200M = 1'b1;

    // Thresholds near the top of the range do not wrap; base 0 gives symbol 0
    bin_base_i = 16'hFFF0;
    bin_step_i = 16'h0010;
    exp_q.push_back({2'd3, 16'd200});
    drive_periods(40, 6);
    bin_base_i = 16'd0;
    exp_q.push_back({2'd0, 16'd200});
    drive_periods(40, 5);
    check_eq("valid_count_d", 32'(valid_cnt), 32'd10);

    // Sub-cycle jitter on a 40 clk period
    bin_base_i = 16'd190;
    bin_step_i = 16'd5;
    jit_mode = 1'b1;
    drive_jitter(15);
    repeat (10) @(negedge clk_200M);
    jit_mode = 1'b0;
    check_eq("jit_windows", 32'(jit_cnt), 32'd3);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
